// File: rtl/multi_debounce_if.sv
// Pin bundle for multi_debounce: raw pins in, debounced levels and edge pulses out.
// Latency: none, wires only.
// Backpressure: none; pins and outputs are free-running levels.
interface multi_debounce_if #(
  parameter int CH = 4
);
  logic [CH-1:0] Pin_In;
  logic [CH-1:0] Pin_Out;
  logic [CH-1:0] Rise_Pulse;
  logic [CH-1:0] Fall_Pulse;

  // Environment side: drives the raw pins, observes the debounced results.
  modport master (
    output Pin_In,
    input  Pin_Out,
    input  Rise_Pulse,
    input  Fall_Pulse
  );

  // Debouncer side.
  modport slave (
    input  Pin_In,
    output Pin_Out,
    output Rise_Pulse,
    output Fall_Pulse
  );
endinterface

// File: rtl/multi_debounce.sv
// Purpose: CH-channel debouncer with a shared ms prescaler and per-channel IDLE/CHECK FSM.
// Latency: accepted change after DB_MS-1..DB_MS tick periods plus 3 clocks sync/register.
// Backpressure: none; optional edge pulses built only when MULTI_DEBOUNCE_PULSE_EN is defined.
module multi_debounce #(
  parameter int CH       = 4,
  parameter int TICK_DIV = 49_999,
  parameter int DB_MS    = 10
) (
  input  logic           CLOCK,
  input  logic           RST_n,
  multi_debounce_if.slave io
);

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  localparam logic [15:0] TICK_TC = 16'(TICK_DIV);
  localparam logic [7:0]  CNT_TC  = 8'(DB_MS - 1);

  logic [CH-1:0] sync_q1;
  logic [CH-1:0] sync_q2;
  logic [15:0]   pres_q;
  logic          tick;
  state_t        state_q [CH];
  state_t        state_d [CH];
  logic [7:0]    cnt_q   [CH];
  logic [7:0]    cnt_d   [CH];
  logic [CH-1:0] out_q;
  logic [CH-1:0] toggle;

  // Two-flop synchronizer on every raw pin; only sync_q2 is used downstream.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= io.Pin_In;
      sync_q2 <= sync_q1;
    end
  end

  // Shared free-running prescaler; tick marks the terminal-count clock.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      pres_q <= '0;
    end else if (pres_q == TICK_TC) begin
      pres_q <= '0;
    end else begin
      pres_q <= pres_q + 16'd1;
    end
  end

  assign tick = (pres_q == TICK_TC);

  // Per-channel state and tick counter registers.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next-state logic: a mismatch must persist across DB_MS ticks; any match aborts first.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    toggle  = '0;
    for (int i = 0; i < CH; i++) begin
      case (state_q[i])
        IDLE: begin
          cnt_d[i] = '0;
          if (sync_q2[i] != out_q[i]) begin
            state_d[i] = CHECK;
          end
        end
        CHECK: begin
          if (sync_q2[i] == out_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (tick) begin
            if (cnt_q[i] == CNT_TC) begin
              toggle[i]  = 1'b1;
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 8'd1;
            end
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Debounced level flips when its channel qualifies.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_q ^ toggle;
    end
  end

  assign io.Pin_Out = out_q;

`ifdef MULTI_DEBOUNCE_PULSE_EN
  logic [CH-1:0] rise_q;
  logic [CH-1:0] fall_q;

  // Edge pulses register alongside out_q so they line up with the new level.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= toggle & ~out_q;
      fall_q <= toggle & out_q;
    end
  end

  assign io.Rise_Pulse = rise_q;
  assign io.Fall_Pulse = fall_q;
`else
  assign io.Rise_Pulse = '0;
  assign io.Fall_Pulse = '0;
`endif

endmodule

// File: tb/tb_multi_debounce.sv
// Directed bench for multi_debounce with CH=4, TICK_DIV=9, DB_MS=3 (tick every 10 clocks).
// Latency windows are checked against hand-derived bounds from the pin change or reset release.
// Pulse expectations follow whether MULTI_DEBOUNCE_PULSE_EN is defined.
module tb_multi_debounce;

  localparam int CH = 4;

`ifdef MULTI_DEBOUNCE_PULSE_EN
  localparam bit PULSE = 1'b1;
`else
  localparam bit PULSE = 1'b0;
`endif

  logic CLOCK;
  logic RST_n;
  int   checks;
  int   failures;
  int   n;
  bit   quiet;

  multi_debounce_if #(.CH(CH)) bus ();

  multi_debounce #(
    .CH      (CH),
    .TICK_DIV(9),
    .DB_MS   (3)
  ) dut (
    .CLOCK(CLOCK),
    .RST_n(RST_n),
    .io   (bus.slave)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  // Counts clock edges until Pin_Out[ch] reaches lvl; 999 marks a timeout.
  task automatic wait_out(input int ch, input logic lvl, output int cnt);
    cnt = 999;
    for (int k = 1; k <= 80; k++) begin
      step();
      if (bus.Pin_Out[ch] === lvl) begin
        cnt = k;
        break;
      end
    end
  endtask

  function automatic logic [31:0] pexp(input logic [3:0] v);
    return PULSE ? {28'd0, v} : 32'd0;
  endfunction

  initial begin
    checks     = 0;
    failures   = 0;
    bus.Pin_In = '0;
    RST_n      = 1'b0;
    repeat (3) @(negedge CLOCK);
    chk("reset_out",  {28'd0, bus.Pin_Out},    32'd0);
    chk("reset_rise", {28'd0, bus.Rise_Pulse}, 32'd0);
    chk("reset_fall", {28'd0, bus.Fall_Pulse}, 32'd0);
    RST_n = 1'b1;
    repeat (7) @(negedge CLOCK);

    // Clean press on channel 0.
    bus.Pin_In[0] = 1'b1;
    wait_out(0, 1'b1, n);
    chk("press_win", {31'd0, (n >= 20 && n <= 33)}, 32'd1);
    chk("press_out", {28'd0, bus.Pin_Out}, 32'h1);
    chk("press_rise", {28'd0, bus.Rise_Pulse}, pexp(4'b0001));
    chk("press_fall", {28'd0, bus.Fall_Pulse}, 32'd0);
    step();
    chk("press_rise_1clk", {28'd0, bus.Rise_Pulse}, 32'd0);
    chk("press_hold", {28'd0, bus.Pin_Out}, 32'h1);

    // Bounce on channel 1: 7-clock toggles never survive three ticks.
    quiet = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (k % 7 == 0) bus.Pin_In[1] = ~bus.Pin_In[1];
      step();
      if (bus.Pin_Out[1] !== 1'b0 || bus.Rise_Pulse[1] !== 1'b0 || bus.Fall_Pulse[1] !== 1'b0)
        quiet = 1'b0;
    end
    bus.Pin_In[1] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.Pin_Out[1] !== 1'b0 || bus.Rise_Pulse[1] !== 1'b0 || bus.Fall_Pulse[1] !== 1'b0)
        quiet = 1'b0;
    end
    chk("bounce_quiet", {31'd0, quiet}, 32'd1);
    chk("bounce_out", {28'd0, bus.Pin_Out}, 32'h1);

    // Release on channel 2 after first bringing it high.
    bus.Pin_In[2] = 1'b1;
    wait_out(2, 1'b1, n);
    chk("ch2_up_win", {31'd0, (n >= 20 && n <= 33)}, 32'd1);
    step();
    bus.Pin_In[2] = 1'b0;
    wait_out(2, 1'b0, n);
    chk("release_win", {31'd0, (n >= 20 && n <= 33)}, 32'd1);
    chk("release_out", {28'd0, bus.Pin_Out}, 32'h1);
    chk("release_fall", {28'd0, bus.Fall_Pulse}, pexp(4'b0100));
    chk("release_rise", {28'd0, bus.Rise_Pulse}, 32'd0);
    step();
    chk("release_fall_1clk", {28'd0, bus.Fall_Pulse}, 32'd0);

    // Drop channel 0 so every output is low, then raise all four at once.
    bus.Pin_In = '0;
    wait_out(0, 1'b0, n);
    chk("ch0_down_win", {31'd0, (n >= 20 && n <= 33)}, 32'd1);
    chk("ch0_down_fall", {28'd0, bus.Fall_Pulse}, pexp(4'b0001));
    repeat (5) step();
    bus.Pin_In = 4'b1111;
    wait_out(3, 1'b1, n);
    chk("simul_win", {31'd0, (n >= 20 && n <= 33)}, 32'd1);
    chk("simul_out", {28'd0, bus.Pin_Out}, 32'hF);
    chk("simul_rise", {28'd0, bus.Rise_Pulse}, pexp(4'b1111));
    step();
    chk("simul_rise_1clk", {28'd0, bus.Rise_Pulse}, 32'd0);

    // Reset while channel 0 is mid-qualification with its pin held high.
    bus.Pin_In = '0;
    repeat (45) step();
    chk("all_low", {28'd0, bus.Pin_Out}, 32'd0);
    @(negedge CLOCK);
    bus.Pin_In[0] = 1'b1;
    repeat (15) @(negedge CLOCK);
    chk("pre_reset_out", {28'd0, bus.Pin_Out}, 32'd0);
    RST_n = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLOCK);
      if (bus.Pin_Out !== 4'd0 || bus.Rise_Pulse !== 4'd0 || bus.Fall_Pulse !== 4'd0)
        quiet = 1'b0;
    end
    chk("mid_reset_quiet", {31'd0, quiet}, 32'd1);
    RST_n = 1'b1;
    wait_out(0, 1'b1, n);
    chk("post_reset_win", {31'd0, (n >= 20 && n <= 33)}, 32'd1);
    chk("post_reset_rise", {28'd0, bus.Rise_Pulse}, pexp(4'b0001));
    chk("post_reset_out", {28'd0, bus.Pin_Out}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
